// File: rtl/dmem_seq_pkg.sv
// Shared types and constants for the byte-sequenced data-memory arbiter.
package dmem_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_FINISH = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int BEATS  = 4;
  localparam int BEAT_W = 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = 2'(BEATS - 1);

  localparam logic P_CPU = 1'b0;
  localparam logic P_LDR = 1'b1;

  // Big-endian beat order: beat 0 carries the most significant byte.
  function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [BEAT_W-1:0] k);
    case (k)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/dmem_seq_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: combinational one-hot grant, registered last winner.
module rr_arb2
  import dmem_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == P_LDR) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Reset to the loader so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last <= P_LDR;
    end else if (upd && (|req)) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/dmem_seq_arbiter.sv
// Shares a 256x8 single-port memory between two 32-bit requesters, one word as four
// big-endian byte beats per transaction; 7 cycles per word, all outputs registered.
module dmem_seq_arbiter
  import dmem_seq_pkg::*;
#(
  parameter int MEM_AW = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);

  state_t              state;
  logic [BEAT_W-1:0]   beat;
  logic [BEAT_W-1:0]   beat_nx;
  logic                id_q;
  logic                we_q;
  logic [MEM_AW-1:0]   base_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                re_d;
  logic [BEAT_W-1:0]   idx_d;

  logic [1:0]          arb_gnt;
  logic                we_sel;
  logic [31:0]         addr_sel;
  logic [DATA_W-1:0]   wdata_sel;
  logic [MEM_AW-1:0]   base_sel;
  logic                unused_addr;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({req1, req0}),
    .upd (state == S_IDLE),
    .gnt (arb_gnt)
  );

  assign we_sel    = arb_gnt[1] ? we1    : we0;
  assign addr_sel  = arb_gnt[1] ? addr1  : addr0;
  assign wdata_sel = arb_gnt[1] ? wdata1 : wdata0;
  assign base_sel  = {addr_sel[MEM_AW-1:2], 2'b00};
  assign beat_nx   = beat + 1'b1;

  assign unused_addr = ^{addr0[31:MEM_AW], addr0[1:0], addr1[31:MEM_AW], addr1[1:0],
                         addr_sel[31:MEM_AW], addr_sel[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      beat      <= '0;
      id_q      <= P_CPU;
      we_q      <= 1'b0;
      base_q    <= '0;
      wdata_q   <= '0;
      re_d      <= 1'b0;
      idx_d     <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;

      // Memory returns a byte one cycle after the strobe; land it the cycle after that.
      re_d  <= mem_re;
      idx_d <= beat;
      if (re_d) begin
        case (idx_d)
          2'd0:    rdata[31:24] <= mem_rdata;
          2'd1:    rdata[23:16] <= mem_rdata;
          2'd2:    rdata[15:8]  <= mem_rdata;
          default: rdata[7:0]   <= mem_rdata;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (|arb_gnt) begin
            id_q      <= arb_gnt[1];
            we_q      <= we_sel;
            base_q    <= base_sel;
            wdata_q   <= wdata_sel;
            gnt0      <= arb_gnt[0];
            gnt1      <= arb_gnt[1];
            beat      <= '0;
            mem_addr  <= base_sel;
            mem_we    <= we_sel;
            mem_re    <= !we_sel;
            mem_wdata <= be_byte(wdata_sel, '0);
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (beat == LAST_BEAT) begin
            state <= S_FINISH;
          end else begin
            beat      <= beat_nx;
            mem_addr  <= base_q + MEM_AW'(beat_nx);
            mem_we    <= we_q;
            mem_re    <= !we_q;
            mem_wdata <= be_byte(wdata_q, beat_nx);
          end
        end
        S_FINISH: begin
          done0 <= (id_q == P_CPU);
          done1 <= (id_q == P_LDR);
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
